// File: rtl/des_pkg.sv
// des_pkg: FrontPanel endpoint map, control bit positions and sequencer states shared by the DES block controller
package des_pkg;
    localparam logic [7:0] EP_WIRE_CTRL  = 8'h10;
    localparam logic [7:0] EP_TRIG_START = 8'h40;
    localparam logic [7:0] EP_TRIG_PTR   = 8'h41;
    localparam logic [7:0] EP_TRIG_DONE  = 8'h60;
    localparam logic [7:0] EP_PIPE_IN    = 8'h80;
    localparam logic [7:0] EP_PIPE_OUT   = 8'hA0;
    localparam int BIT_RESET     = 0;
    localparam int BIT_DECRYPT   = 4;
    localparam int BIT_START     = 0;
    localparam int BIT_PTR_RESET = 0;
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, ISSUE, WAIT, WR_LO, WR_HI, FINISH} state_t;
endpackage

// File: rtl/des_block_ctrl_if.sv
// des_block_ctrl_if: pipe-in/pipe-out strobes and DES core handshake between the host side and the device
interface des_block_ctrl_if;
    logic        pi_write;
    logic [31:0] pi_data;
    logic        po_read;
    logic [31:0] po_data;
    logic        des_start;
    logic        des_decrypt;
    logic [63:0] des_din;
    logic [63:0] des_dout;
    logic        des_done;
    modport master (
        output pi_write, pi_data, po_read, des_dout, des_done,
        input  po_data, des_start, des_decrypt, des_din
    );
    modport slave (
        input  pi_write, pi_data, po_read, des_dout, des_done,
        output po_data, des_start, des_decrypt, des_din
    );
endinterface

// File: rtl/des_buf_ram.sv
// des_buf_ram: single-clock word buffer with one write port and one registered read port
module des_buf_ram #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [2**AW];
    logic [31:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else rdata_q <= mem[raddr];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/des_block_ctrl.sv
// des_block_ctrl: buffers pipe-in words, runs each 64-bit block through an external DES core in place, serves results on pipe-out
module des_block_ctrl
    import des_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                okClk,
    input  logic                reset,
    input  logic                ptr_reset,
    input  logic                start,
    input  logic                decrypt,
    des_block_ctrl_if.slave     bus,
    output logic                done_trig,
    output logic                busy,
    output logic [DEPTH_LOG2:0] word_count,
    output logic                overflow
);
    localparam int AW = DEPTH_LOG2;
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
    state_t state_q, state_d;
    logic [AW-2:0] blk_q, blk_d;
    logic [AW:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic ovf_q, ovf_d, dec_q, dec_d, busy_q, busy_d, done_q, done_d;
    logic [63:0] din_q, din_d, res_q, res_d;
    logic we, tail, more;
    logic [AW-1:0] waddr, raddr, lo_addr, hi_addr;
    logic [31:0] wdata, rdata, hi_word;
    assign lo_addr = {blk_q, 1'b0};
    assign hi_addr = {blk_q, 1'b1};
    assign tail = {1'b0, hi_addr} == count_q;
    assign more = {1'b0, lo_addr} + (AW+1)'(2) < count_q;
    assign hi_word = tail ? '0 : rdata;
    // Idle reads follow the next pointer so pipe-out data is ready the cycle after po_read
    assign raddr = (state_q == IDLE || state_q == FINISH) ? rd_ptr_d : (state_q == RD_HI ? hi_addr : lo_addr);
    always_comb begin
        state_d = state_q;
        blk_d = blk_q;
        count_d = count_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d = ovf_q;
        dec_d = dec_q;
        din_d = din_q;
        res_d = res_q;
        we = 1'b0;
        waddr = lo_addr;
        wdata = res_q[31:0];
        case (state_q)
            IDLE: begin
                if (ptr_reset) begin
                    count_d = '0;
                    rd_ptr_d = '0;
                    ovf_d = 1'b0;
                end else begin
                    if (bus.pi_write && count_q == FULL) ovf_d = 1'b1;
                    if (bus.pi_write && count_q != FULL) begin
                        we = 1'b1;
                        waddr = count_q[AW-1:0];
                        wdata = bus.pi_data;
                        count_d = count_q + 1'b1;
                    end
                    rd_ptr_d = bus.po_read ? rd_ptr_q + 1'b1 : rd_ptr_q;
                    if (start) begin
                        dec_d = decrypt;
                        blk_d = '0;
                        state_d = count_q == '0 ? FINISH : RD_LO;
                    end
                end
            end
            RD_LO: state_d = RD_HI;
            RD_HI: begin
                din_d[31:0] = rdata;
                state_d = ISSUE;
            end
            ISSUE: begin
                din_d[63:32] = hi_word;
                state_d = WAIT;
            end
            WAIT: begin
                res_d = bus.des_done ? bus.des_dout : res_q;
                state_d = bus.des_done ? WR_LO : WAIT;
            end
            WR_LO: begin
                we = 1'b1;
                state_d = tail ? FINISH : WR_HI;
            end
            WR_HI: begin
                we = 1'b1;
                waddr = hi_addr;
                wdata = res_q[63:32];
                blk_d = blk_q + 1'b1;
                state_d = more ? RD_LO : FINISH;
            end
            FINISH: begin
                rd_ptr_d = '0;
                state_d = IDLE;
            end
        endcase
        if (state_q != IDLE && bus.pi_write) ovf_d = 1'b1;
        busy_d = state_d != IDLE;
        done_d = state_q == FINISH;
    end
    always_ff @(posedge okClk) begin
        if (reset) begin
            state_q <= IDLE;
            blk_q <= '0;
            count_q <= '0;
            rd_ptr_q <= '0;
            ovf_q <= 1'b0;
            dec_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            din_q <= '0;
            res_q <= '0;
        end else begin
            state_q <= state_d;
            blk_q <= blk_d;
            count_q <= count_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q <= ovf_d;
            dec_q <= dec_d;
            busy_q <= busy_d;
            done_q <= done_d;
            din_q <= din_d;
            res_q <= res_d;
        end
    end
    des_buf_ram #(.AW(AW)) u_ram (
        .clk   (okClk),
        .rst   (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );
    assign bus.po_data = rdata;
    assign bus.des_start = state_q == ISSUE;
    assign bus.des_decrypt = dec_q;
    assign bus.des_din = state_q == ISSUE ? {hi_word, din_q[31:0]} : din_q;
    assign done_trig = done_q;
    assign busy = busy_q;
    assign word_count = count_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_des_block_ctrl.sv
// tb_des_block_ctrl: directed bench with a transaction-level buffer model, an XOR DES stub and a per-cycle output compare
module tb_des_block_ctrl;
    localparam int L = 3;
    localparam logic [63:0] MASK = 64'hFFFF0000_FFFF0000;
    localparam logic [31:0] MASK32 = 32'hFFFF0000;
    logic clk, reset, ptr_reset, start, decrypt;
    logic done_trig, busy, overflow;
    logic [9:0] word_count;
    des_block_ctrl_if bus();
    des_block_ctrl #(.DEPTH_LOG2(9)) dut (
        .okClk      (clk),
        .reset      (reset),
        .ptr_reset  (ptr_reset),
        .start      (start),
        .decrypt    (decrypt),
        .bus        (bus),
        .done_trig  (done_trig),
        .busy       (busy),
        .word_count (word_count),
        .overflow   (overflow)
    );
    int n_vec = 0, n_err = 0;
    int busy_cnt = 0, done_cnt = 0, start_cnt = 0, dec_cnt = 0;
    logic [31:0] m_mem [512];
    int m_count = 0;
    logic [8:0] m_rd = '0;
    logic m_ovf = 0, m_busy = 0, m_done = 0, m_dec = 0;
    logic chk_en = 0, po_chk = 0;
    logic [63:0] exp_q[$];
    logic [31:0] got[$];
    logic [63:0] last_din = '0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done_trig", 64'(done_trig), 64'(m_done));
            chk("word_count", 64'(word_count), 64'(m_count));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (po_chk && !m_busy) chk("po_data", 64'(bus.po_data), 64'(m_mem[m_rd]));
        end
        if (busy) busy_cnt++;
        if (done_trig) done_cnt++;
    end

    // DES core stub: result is din ^ MASK, done L cycles after start
    initial begin
        logic [63:0] d;
        bus.des_done = 0;
        bus.des_dout = '0;
        forever begin
            @(negedge clk);
            if (bus.des_start) begin
                d = bus.des_din;
                last_din = d;
                start_cnt++;
                if (bus.des_decrypt) dec_cnt++;
                chk("des_decrypt", 64'(bus.des_decrypt), 64'(m_dec));
                if (exp_q.size() == 0) chk("des_start_unexpected", 64'(1), 64'(0));
                else chk("des_din", d, exp_q.pop_front());
                repeat (L) @(negedge clk);
                bus.des_dout = d ^ MASK;
                bus.des_done = 1;
                @(negedge clk);
                bus.des_done = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic clr();
        busy_cnt = 0;
        done_cnt = 0;
        start_cnt = 0;
        dec_cnt = 0;
    endtask

    task automatic wr(input logic [31:0] d);
        bus.pi_write = 1;
        bus.pi_data = d;
        @(posedge clk); #1;
        bus.pi_write = 0;
        if (m_count == 512) m_ovf = 1;
        else begin
            m_mem[m_count] = d;
            m_count++;
        end
    endtask

    task automatic ptr();
        ptr_reset = 1;
        @(posedge clk); #1;
        ptr_reset = 0;
        m_count = 0;
        m_rd = '0;
        m_ovf = 0;
    endtask

    task automatic rd(input int n);
        got.delete();
        po_chk = 1;
        for (int i = 0; i < n; i++) begin
            bus.po_read = 1;
            @(negedge clk);
            got.push_back(bus.po_data);
            @(posedge clk); #1;
            m_rd = m_rd + 1'b1;
        end
        bus.po_read = 0;
        @(negedge clk);
        @(posedge clk); #1;
        po_chk = 0;
    endtask

    // Busy lasts (5+L) per full block, one less for an odd tail, plus the finishing cycle
    task automatic run(input logic dec, input logic tog, input logic inj, input int abort);
        int nb, cyc;
        logic odd;
        nb = (m_count + 1) / 2;
        odd = (m_count % 2) == 1;
        cyc = nb * (5 + L) - (odd ? 1 : 0) + 1;
        for (int b = 0; b < nb; b++)
            exp_q.push_back({(odd && b == nb - 1) ? 32'h0 : m_mem[2*b+1], m_mem[2*b]});
        start = 1;
        decrypt = dec;
        @(posedge clk); #1;
        start = 0;
        m_dec = dec;
        m_busy = 1;
        for (int i = 1; i < cyc; i++) begin
            if (i == abort) begin
                reset = 1;
                @(posedge clk); #1;
                reset = 0;
                m_busy = 0;
                m_count = 0;
                m_ovf = 0;
                m_rd = '0;
                m_dec = 0;
                exp_q.delete();
                return;
            end
            if (i == 2 && tog) decrypt = ~dec;
            if (i == 2 && inj) bus.pi_write = 1;
            @(posedge clk); #1;
            if (i == 2 && inj) begin
                bus.pi_write = 0;
                m_ovf = 1;
            end
        end
        @(posedge clk); #1;
        m_busy = 0;
        m_done = 1;
        m_rd = '0;
        for (int b = 0; b < nb; b++) begin
            m_mem[2*b] = m_mem[2*b] ^ MASK32;
            if (!(odd && b == nb - 1)) m_mem[2*b+1] = m_mem[2*b+1] ^ MASK32;
        end
        @(posedge clk); #1;
        m_done = 0;
        chk("blocks_left", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        reset = 1;
        ptr_reset = 0;
        start = 0;
        decrypt = 0;
        bus.pi_write = 0;
        bus.pi_data = '0;
        bus.po_read = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done_trig), 64'(0));
        chk("rst_word_count", 64'(word_count), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_des_start", 64'(bus.des_start), 64'(0));
        chk("rst_des_din", bus.des_din, 64'(0));
        chk("rst_des_decrypt", 64'(bus.des_decrypt), 64'(0));
        chk("rst_po_data", 64'(bus.po_data), 64'(0));
        chk_en = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) wr(32'((i + 1) * 32'h11111111));
        clr();
        run(0, 0, 0, -1);
        chk("t1_busy_cycles", 64'(busy_cnt), 64'(17));
        chk("t1_done_pulses", 64'(done_cnt), 64'(1));
        rd(4);
        chk("t1_word0", 64'(got[0]), 64'(32'hEEEE1111));
        chk("t1_word3", 64'(got[3]), 64'(32'hBBBB4444));

        ptr();
        wr(32'hA);
        wr(32'hB);
        wr(32'hC);
        clr();
        run(0, 0, 0, -1);
        chk("t2_tail_din", last_din, 64'h0000_0000_0000_000C);
        chk("t2_busy_cycles", 64'(busy_cnt), 64'(16));
        rd(4);
        chk("t2_word0", 64'(got[0]), 64'(32'hFFFF000A));
        chk("t2_word2", 64'(got[2]), 64'(32'hFFFF000C));
        chk("t2_ram3_untouched", 64'(got[3]), 64'(32'hBBBB4444));

        ptr();
        clr();
        run(0, 0, 0, -1);
        chk("t3_no_des_start", 64'(start_cnt), 64'(0));
        chk("t3_done_pulses", 64'(done_cnt), 64'(1));
        chk("t3_busy_cycles", 64'(busy_cnt), 64'(1));

        for (int i = 0; i < 513; i++) wr(32'(i));
        @(negedge clk);
        chk("t4_full_count", 64'(word_count), 64'(512));
        chk("t4_overflow", 64'(overflow), 64'(1));
        @(posedge clk); #1;
        ptr();
        @(negedge clk);
        chk("t4_ptr_count", 64'(word_count), 64'(0));
        chk("t4_ptr_overflow", 64'(overflow), 64'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) wr(32'h5A5A0000 + 32'(i));
        clr();
        run(1, 1, 1, -1);
        chk("t5_busy_write_ovf", 64'(overflow), 64'(1));
        chk("t5_word_count", 64'(word_count), 64'(4));
        chk("t5_starts", 64'(start_cnt), 64'(2));
        chk("t5_decrypt_held", 64'(dec_cnt), 64'(2));

        ptr();
        wr(32'h01234567);
        wr(32'h89ABCDEF);
        clr();
        run(0, 0, 0, 5);
        @(negedge clk);
        chk("t6_abort_busy", 64'(busy), 64'(0));
        chk("t6_abort_count", 64'(word_count), 64'(0));
        repeat (10) @(posedge clk);
        #1;
        chk("t6_abort_no_done", 64'(done_cnt), 64'(0));

        wr(32'hCAFE0001);
        wr(32'hCAFE0002);
        clr();
        start = 1;
        ptr_reset = 1;
        @(posedge clk); #1;
        start = 0;
        ptr_reset = 0;
        m_count = 0;
        m_rd = '0;
        m_ovf = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("t7_no_busy", 64'(busy_cnt), 64'(0));
        chk("t7_no_start", 64'(start_cnt), 64'(0));
        chk("t7_count_cleared", 64'(word_count), 64'(0));

        for (int i = 0; i < 4; i++) wr(32'((i + 1) * 32'h11111111));
        rd(4);
        chk("t8_word1", 64'(got[1]), 64'(32'h22222222));
        chk("t8_word3", 64'(got[3]), 64'(32'h44444444));

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/des_block_ctrl.md
Name: des_block_ctrl

Overview:
- Device-side responder for the DES host flow.
- Buffers 32-bit pipe-in words into an internal RAM.
- On a start trigger, runs each 64-bit block through an external DES core in place, then pulses a done trigger.
- Serves the processed words back on the pipe-out port.
- Sits between the FrontPanel endpoints (wire 0x10, trigger-ins 0x40/0x41, pipe-in 0x80, trigger-out 0x60, pipe-out 0xA0) and the DES core.

Parameters:
- DEPTH_LOG2, 9: log2 of buffer depth in 32-bit words (512 words).

Ports:
- okClk  in  1  interface clock; all logic on rising edge
- reset  in  1  synchronous, active-high (wire 0x10 bit0)
- ptr_reset  in  1  one-cycle pulse (trigger 0x41 bit0); clears pointers/count/overflow
- start  in  1  one-cycle pulse (trigger 0x40 bit0); begin processing
- decrypt  in  1  level (wire 0x10 bit4); sampled at start, forwarded as des_decrypt
- pi_write  in  1  pipe-in strobe
- pi_data  in  32  pipe-in word
- po_read  in  1  pipe-out strobe
- po_data  out  32  pipe-out word, first-word-fall-through
- des_start  out  1  one-cycle request to DES core
- des_decrypt  out  1  mode latched at start
- des_din  out  64  block to core, {hi word, lo word}
- des_dout  in  64  core result, valid when des_done=1
- des_done  in  1  one-cycle pulse, any latency >=1 after des_start
- done_trig  out  1  one-cycle pulse (trigger-out 0x60 bit0)
- busy  out  1  high while processing
- word_count  out  DEPTH_LOG2+1  words written since ptr_reset
- overflow  out  1  sticky; pipe-in write dropped

Behaviour:
- Reset values: all outputs 0, pointers 0, state IDLE, RAM contents undefined.
- Reset mid-operation aborts processing immediately; no done_trig is issued.
- Pipe-in, IDLE only:
  - pi_write stores pi_data at wr_ptr, then wr_ptr++ and word_count++.
  - At word_count = 2^DEPTH_LOG2 the write is dropped and overflow is set.
  - Writes while busy are dropped and set overflow.
- Pipe-out:
  - po_data continuously shows RAM[rd_ptr].
  - po_read advances rd_ptr; the new word is valid the next cycle (prefetch through a lookahead address).
  - rd_ptr wraps modulo depth; reads past word_count return stale RAM.
  - po_read while busy is ignored.
- ptr_reset: IDLE only; clears wr_ptr, rd_ptr, word_count and overflow. Ignored while busy.
- Block format: block i = {RAM[2i+1], RAM[2i]}; the result is written back to the same addresses.
- Odd word_count: the final block's hi word is forced to 0, and only its lo result is written back.
- FSM states: IDLE, RD_LO, RD_HI, ISSUE, WAIT, WR_LO, WR_HI, FINISH.
  - IDLE: on start, latch decrypt, set blk=0, busy=1 next cycle. If word_count=0, go to FINISH.
  - RD_LO: present addr 2*blk.
  - RD_HI: present addr 2*blk+1; capture lo.
  - ISSUE: capture hi (or 0 for an odd tail); drive des_din; des_start=1 for exactly one cycle.
  - WAIT: hold until des_done; latch des_dout.
  - WR_LO: write lo.
  - WR_HI: write hi (skipped for an odd tail). Then blk++; if more words remain go to RD_LO, else FINISH.
  - FINISH: done_trig=1 for one cycle, busy=0 in the same cycle, rd_ptr cleared, return to IDLE.
- Per-block latency: 5 + L cycles, where L is the des_start-to-des_done delay.
- start while busy is ignored. A des_done outside WAIT is ignored.
- start and ptr_reset in the same IDLE cycle: ptr_reset wins and start is dropped.

Decomposition:
- Shared package des_pkg holds:
  - endpoint address constants (0x10, 0x40, 0x41, 0x60, 0x80, 0xA0);
  - bit indices for reset, decrypt, start and ptr_reset;
  - the FSM state enum.
- One sub-module: des_buf_ram, a single-clock RAM with one write port and one synchronous-read port.
  - Read address is muxed: FSM while busy, pipe-out lookahead while idle.

Test Plan:
- DES core stub for all tests: des_dout = des_din ^ 64'hFFFF0000_FFFF0000, done 3 cycles after start.
- Write 4 words 0x11111111..0x44444444, start, read 4 -> done_trig once, 0x11111111^0xFFFF0000 first; busy high 2*(5+3)+1 cycles.
- Odd count: write 3 words 0xA, 0xB, 0xC, start -> des_din for block 1 = {0, 0xC}; readback word2 = 0xFFFF000C; RAM[3] untouched.
- Start with word_count=0 -> done_trig one cycle after start; des_start never asserted.
- Overflow and reset interplay:
  - Write 513 words (DEPTH_LOG2=9) -> word_count=512, overflow=1.
  - ptr_reset -> word_count=0, overflow=0.
  - pi_write during busy -> dropped, overflow=1.
- decrypt=1 at start, toggled mid-run -> des_decrypt stays 1 for all blocks. Reset asserted in WAIT -> busy=0, no done_trig, word_count=0.
- start and ptr_reset in the same cycle -> no processing, pointers cleared. po_read pulses back-to-back -> consecutive words with no bubble.
